// File: rtl/tone_spi_pkg.sv
// Shared definitions for the tone-generator SPI register controller.
//   CMD_READ_BIT    : command-byte bit selecting read (1) or write (0)
//   DEF_ADDR_WIDTH  : default register address width
//   DEF_STATUS_ADDR : default read-only status address
//   state_t         : controller FSM states
package tone_spi_pkg;

    localparam int unsigned CMD_READ_BIT    = 7;
    localparam int unsigned DEF_ADDR_WIDTH  = 4;
    localparam logic [3:0]  DEF_STATUS_ADDR = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WRITE,
        READ
    } state_t;

endpackage

// File: rtl/spi_reg_file.sv
// Register file for the SPI register controller: 2**ADDR_WIDTH x 8-bit flops.
//   clk_in, reset_n_in : clock, asynchronous active-low reset (clears all regs)
//   wr_en, wr_addr, wr_data : single synchronous write port
//   rd_addr, rd_data   : combinational read port
//   regs               : flat contents, reg k at [8k+7:8k]
module spi_reg_file
    import tone_spi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
)
(
    input  logic                           clk_in,
    input  logic                           reset_n_in,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [7:0]                     wr_data,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [7:0]                     rd_data,
    output logic [(2**ADDR_WIDTH)*8-1:0]   regs
);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            regs <= '0;
        end else if (wr_en) begin
            regs[wr_addr*8 +: 8] <= wr_data;
        end
    end

    assign rd_data = regs[rd_addr*8 +: 8];

endmodule

// File: rtl/spi_reg_ctrl.sv
// Command decoder / register sequencer behind the SPI slave byte interface.
// The first byte of each CS-framed transaction is a command (bit7 = read,
// low ADDR_WIDTH bits = address); following bytes are write data or dummy
// bytes that trigger the next read-back load.
//   clk_in, reset_n_in    : clock, asynchronous active-low reset
//   rx_data_in/rx_valid_in: received byte and its one-cycle strobe
//   transaction_valid_in  : high while CS is asserted
//   tx_data_out/tx_valid_out : next MISO byte and its one-cycle load strobe
//   status_in             : live status byte, read at STATUS_ADDR
//   regs_out              : flat register contents
//   wr_strobe_out/wr_addr_out : committed-write pulse and its address
// Build option: define SPI_REG_AUTO_INC_EN to advance the address after each
// write data byte or read load (wrapping modulo NUM_REGS); otherwise the
// address stays fixed for the whole transaction.
module spi_reg_ctrl
    import tone_spi_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR = DEF_STATUS_ADDR
)
(
    input  logic                           clk_in,
    input  logic                           reset_n_in,
    input  logic [7:0]                     rx_data_in,
    input  logic                           rx_valid_in,
    input  logic                           transaction_valid_in,
    output logic [7:0]                     tx_data_out,
    output logic                           tx_valid_out,
    input  logic [7:0]                     status_in,
    output logic [(2**ADDR_WIDTH)*8-1:0]   regs_out,
    output logic                           wr_strobe_out,
    output logic [ADDR_WIDTH-1:0]          wr_addr_out
);

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   addr, addr_next;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [7:0]              rd_data;
    logic [7:0]              rd_value;
    logic                    tx_load;
    logic [7:0]              tx_value;
    logic                    reg_we;

    function automatic logic [ADDR_WIDTH-1:0] advance(input logic [ADDR_WIDTH-1:0] a);
`ifdef SPI_REG_AUTO_INC_EN
        return a + ADDR_WIDTH'(1);
`else
        return a;
`endif
    endfunction

    spi_reg_file #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_reg_file (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .wr_en      (reg_we),
        .wr_addr    (addr),
        .wr_data    (rx_data_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .regs       (regs_out)
    );

    // The command byte's own address feeds the read port so the first
    // read-back load happens on the same edge that leaves CMD.
    assign rd_addr  = (state == CMD) ? rx_data_in[ADDR_WIDTH-1:0] : addr;
    assign rd_value = (rd_addr == STATUS_ADDR) ? status_in : rd_data;

    always_comb begin
        state_next = state;
        addr_next  = addr;
        tx_load    = 1'b0;
        tx_value   = '0;
        reg_we     = 1'b0;

        // Losing CS wins over a coincident byte strobe.
        if (!transaction_valid_in) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    // Zero load keeps MISO quiet for the command byte and
                    // for every byte of a write transaction.
                    state_next = CMD;
                    tx_load    = 1'b1;
                end
                CMD: begin
                    if (rx_valid_in) begin
                        if (rx_data_in[CMD_READ_BIT]) begin
                            state_next = READ;
                            tx_load    = 1'b1;
                            tx_value   = rd_value;
                            addr_next  = advance(rd_addr);
                        end else begin
                            state_next = WRITE;
                            addr_next  = rx_data_in[ADDR_WIDTH-1:0];
                        end
                    end
                end
                WRITE: begin
                    if (rx_valid_in) begin
                        reg_we    = (addr != STATUS_ADDR);
                        addr_next = advance(addr);
                    end
                end
                READ: begin
                    if (rx_valid_in) begin
                        tx_load   = 1'b1;
                        tx_value  = rd_value;
                        addr_next = advance(addr);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state         <= IDLE;
            addr          <= '0;
            tx_data_out   <= '0;
            tx_valid_out  <= 1'b0;
            wr_strobe_out <= 1'b0;
            wr_addr_out   <= '0;
        end else begin
            state         <= state_next;
            addr          <= addr_next;
            tx_valid_out  <= tx_load;
            wr_strobe_out <= reg_we;
            if (tx_load) begin
                tx_data_out <= tx_value;
            end
            if (reg_we) begin
                wr_addr_out <= addr;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    logic         clk_in = 1'b0;
    logic         reset_n_in = 1'b0;
    logic [7:0]   rx_data_in = '0;
    logic         rx_valid_in = 1'b0;
    logic         transaction_valid_in = 1'b0;
    logic [7:0]   status_in = '0;
    logic [7:0]   tx_data_out;
    logic         tx_valid_out;
    logic [127:0] regs_out;
    logic         wr_strobe_out;
    logic [3:0]   wr_addr_out;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;

    // Reference model: transaction-level view (byte index within CS frame).
    logic [7:0] m_regs [16];
    logic [3:0] m_addr = '0;
    logic [3:0] m_wr_addr = '0;
    logic       m_read = 1'b0;
    logic       m_in_txn = 1'b0;
    int         m_idx = 0;
    logic [7:0] m_txd = '0;
    logic       m_txv = 1'b0;
    logic       m_strobe = 1'b0;

    spi_reg_ctrl #(
        .ADDR_WIDTH  (4),
        .STATUS_ADDR (4'hF)
    ) dut (
        .clk_in               (clk_in),
        .reset_n_in           (reset_n_in),
        .rx_data_in           (rx_data_in),
        .rx_valid_in          (rx_valid_in),
        .transaction_valid_in (transaction_valid_in),
        .tx_data_out          (tx_data_out),
        .tx_valid_out         (tx_valid_out),
        .status_in            (status_in),
        .regs_out             (regs_out),
        .wr_strobe_out        (wr_strobe_out),
        .wr_addr_out          (wr_addr_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] step(input logic [3:0] a);
`ifdef SPI_REG_AUTO_INC_EN
        return a + 4'd1;
`else
        return a;
`endif
    endfunction

    function automatic logic [127:0] m_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = m_regs[i];
        return f;
    endfunction

    task automatic m_load();
        m_txv  = 1'b1;
        m_txd  = (m_addr == 4'hF) ? status_in : m_regs[m_addr];
        m_addr = step(m_addr);
    endtask

    // Model update on every edge the DUT sees.
    initial begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        forever begin
            @(posedge clk_in or negedge reset_n_in);
            if (!reset_n_in) begin
                for (int i = 0; i < 16; i++) m_regs[i] = '0;
                m_addr = '0; m_wr_addr = '0; m_read = 1'b0; m_in_txn = 1'b0;
                m_idx = 0; m_txd = '0; m_txv = 1'b0; m_strobe = 1'b0;
            end else begin
                m_txv    = 1'b0;
                m_strobe = 1'b0;
                if (!transaction_valid_in) begin
                    m_in_txn = 1'b0;
                end else if (!m_in_txn) begin
                    m_in_txn = 1'b1;
                    m_idx    = 0;
                    m_txv    = 1'b1;
                    m_txd    = 8'h00;
                end else if (rx_valid_in) begin
                    if (m_idx == 0) begin
                        m_read = rx_data_in[7];
                        m_addr = rx_data_in[3:0];
                        if (m_read) m_load();
                    end else if (m_read) begin
                        m_load();
                    end else begin
                        if (m_addr != 4'hF) begin
                            m_regs[m_addr] = rx_data_in;
                            m_strobe       = 1'b1;
                            m_wr_addr      = m_addr;
                        end
                        m_addr = step(m_addr);
                    end
                    m_idx++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk_in);
            check("tx_valid", tx_valid_out, m_txv);
            check("tx_data", tx_data_out, m_txd);
            check("wr_strobe", wr_strobe_out, m_strobe);
            check("wr_addr", wr_addr_out, m_wr_addr);
            check("regs", regs_out, m_flat());
            if (wr_strobe_out) strobe_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // All driver tasks start and end at posedge+2.
    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic cs_on();
        transaction_valid_in = 1'b1;
        repeat (2) tick();
    endtask

    task automatic cs_off();
        transaction_valid_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_data_in  = b;
        rx_valid_in = 1'b1;
        tick();
        rx_valid_in = 1'b0;
        repeat ($urandom_range(1, 4)) tick();
    endtask

    task automatic send_chk(input logic [7:0] b, input logic [7:0] exp_tx, input string name);
        rx_data_in  = b;
        rx_valid_in = 1'b1;
        tick();
        rx_valid_in = 1'b0;
        @(negedge clk_in);
        check({name, "_txv"}, tx_valid_out, 1'b1);
        check({name, "_txd"}, tx_data_out, exp_tx);
        tick();
        repeat ($urandom_range(0, 3)) tick();
    endtask

    task automatic send_and_drop_cs(input logic [7:0] b);
        rx_data_in           = b;
        rx_valid_in          = 1'b1;
        transaction_valid_in = 1'b0;
        tick();
        rx_valid_in = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #2 reset_n_in = 1'b1;
        @(negedge clk_in);
        check("reset_regs", regs_out, '0);
        check("reset_txv", tx_valid_out, 1'b0);
        check("reset_txd", tx_data_out, 8'h00);
        check("reset_wr_addr", wr_addr_out, 4'h0);
        tick();

        // Single write.
        strobe_cnt = 0;
        cs_on(); send(8'h03); send(8'hA5); cs_off();
        check("wr1_reg3", regs_out[31:24], 8'hA5);
        check("wr1_others", regs_out & ~(128'hFF << 24), '0);
        check("wr1_strobes", strobe_cnt, 1);
        check("wr1_addr", wr_addr_out, 4'h3);
        check("model_reg3", m_regs[3], 8'hA5);

        // Read back.
        cs_on(); send_chk(8'h83, 8'hA5, "rd1"); send(8'h00); cs_off();

        // Burst write across the status address.
        strobe_cnt = 0;
        cs_on(); send(8'h0E); send(8'h11); send(8'h22); send(8'h33); cs_off();
`ifdef SPI_REG_AUTO_INC_EN
        check("burst_reg14", regs_out[119:112], 8'h11);
        check("burst_reg0", regs_out[7:0], 8'h33);
        check("burst_strobes", strobe_cnt, 2);
`else
        check("burst_reg14", regs_out[119:112], 8'h33);
        check("burst_reg0", regs_out[7:0], 8'h00);
        check("burst_strobes", strobe_cnt, 3);
`endif
        check("burst_reg15", regs_out[127:120], 8'h00);

        // Status read and dropped status write.
        status_in = 8'h5C;
        cs_on(); send_chk(8'h8F, 8'h5C, "status_rd"); send(8'h00); cs_off();
        strobe_cnt = 0;
        cs_on(); send(8'h0F); send(8'hFF); cs_off();
        check("status_wr_strobes", strobe_cnt, 0);
        check("status_wr_reg15", regs_out[127:120], 8'h00);

        // Abort mid data byte, then a normal write.
        strobe_cnt = 0;
        cs_on(); send(8'h02); repeat (4) tick(); cs_off();
        check("abort_reg2", regs_out[23:16], 8'h00);
        check("abort_strobes", strobe_cnt, 0);
        cs_on(); send(8'h02); send(8'h77); cs_off();
        check("after_abort_reg2", regs_out[23:16], 8'h77);

        // CS drop coincident with a data byte.
        cs_on(); send(8'h05); send_and_drop_cs(8'h99);
        check("coincident_reg5", regs_out[47:40], 8'h00);

        // Reset between command and data bytes.
        cs_on(); send(8'h06);
        reset_n_in = 1'b0;
        #1;
        check("rst_mid_regs", regs_out, '0);
        check("rst_mid_strobe", wr_strobe_out, 1'b0);
        repeat (3) tick();
        transaction_valid_in = 1'b0;
        tick();
        reset_n_in = 1'b1;
        tick();
        cs_on(); send(8'h06); send(8'h5A); cs_off();
        check("after_rst_regs", regs_out, 128'h5A << 48);

        // Randomized transactions.
        for (int t = 0; t < 60; t++) begin
            int n;
            n = $urandom_range(0, 4);
            status_in = 8'($urandom);
            cs_on();
            send(8'($urandom));
            for (int k = 0; k < n; k++) send(8'($urandom));
            if ($urandom_range(0, 4) == 0) send_and_drop_cs(8'($urandom));
            else cs_off();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command decoder and register-file sequencer behind the SPI slave byte interface of the tone generator.
- Consumes received bytes and their valid strobes, interprets the first byte of each CS-framed transaction as a command (R/W + address), then performs register writes or supplies read-back bytes for MISO.
- Drives the flat configuration bus consumed by the tone-generator channels.

Parameters:
- ADDR_WIDTH, 4, register address width; NUM_REGS = 2**ADDR_WIDTH.
- STATUS_ADDR, 4'hF, read-only address that returns status_in; writes to it are dropped.

Ports:
- clk_in  input  1  system clock; the same clock as the SPI slave.
- reset_n_in  input  1  asynchronous active-low reset.
- rx_data_in  input  8  received byte from the SPI slave.
- rx_valid_in  input  1  one-cycle strobe; rx_data_in is valid.
- transaction_valid_in  input  1  high while CS is asserted (synchronised).
- tx_data_out  output  8  next byte to shift out on MISO.
- tx_valid_out  output  1  one-cycle load strobe for tx_data_out.
- status_in  input  8  live status byte, readable at STATUS_ADDR.
- regs_out  output  NUM_REGS*8  flat register contents; reg k occupies [8k+7:8k].
- wr_strobe_out  output  1  one-cycle pulse per committed register write.
- wr_addr_out  output  ADDR_WIDTH  address of the last committed write.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all registers=0, tx_data_out=0, tx_valid_out=0, wr_strobe_out=0, wr_addr_out=0, addr pointer=0.
- Command byte: bit7=1 read, 0 write; bits[6:ADDR_WIDTH] reserved and ignored; bits[ADDR_WIDTH-1:0]=address.
- FSM states:
  - IDLE -> CMD when transaction_valid_in rises.
  - CMD: on rx_valid_in, latch address; bit7=0 -> WRITE, bit7=1 -> READ.
  - WRITE: each rx_valid_in writes rx_data_in to reg[addr] and pulses wr_strobe_out with wr_addr_out=addr, registered, 1 cycle after rx_valid_in. Address policy per Optional Feature.
  - READ: entered with a tx load of reg[addr], or status_in if addr==STATUS_ADDR. The load is tx_valid_out=1 with tx_data_out=the value, 1 cycle after the command rx_valid_in. That byte shifts out during the second SPI byte. Each further rx_valid_in in READ (dummy byte, contents ignored) issues the next load the same way.
- Any state -> IDLE within 1 cycle of transaction_valid_in low; partial bytes are discarded by the slave, no write occurs.
- Outside a transaction, tx_data_out holds 8'h00 via a load issued on entry to CMD. A write transaction therefore returns zeros on MISO.
- Writes to STATUS_ADDR: no register change, no wr_strobe_out.
- rx_valid_in while in IDLE is ignored.
- transaction_valid_in falling in the same cycle as rx_valid_in: the transaction end wins; the byte is ignored.
- Reset mid-transaction: immediate return to reset values; the transaction is lost.
- Latency budget: the tx load must occur at most 2 cycles after rx_valid_in so it lands before the slave's next falling-sclk buffer copy.

Optional Feature:
- Macro SPI_REG_AUTO_INC_EN.
- Defined: after each WRITE data byte or READ load, addr increments modulo NUM_REGS (0xF wraps to 0x0), enabling bursts.
- Undefined: addr stays fixed for the whole transaction. Repeated writes overwrite the same register; repeated reads return the same register.

Decomposition:
- Package tone_spi_pkg:
  - CMD_READ_BIT=7.
  - State enum {IDLE, CMD, WRITE, READ}.
  - ADDR_WIDTH default.
  - STATUS_ADDR default.
- Sub-module spi_reg_file: NUM_REGS x 8 flops with async reset, one write port, one combinational read port, flat output.
- The FSM, tx load logic and strobes stay in spi_reg_ctrl.

Test Plan:
- Write single: CS low, bytes 0x03,0xA5, CS high -> regs_out[31:24]=0xA5, one wr_strobe_out with wr_addr_out=3, other regs 0.
- Read back: after the above, bytes 0x83,0x00 -> tx_valid_out 1 cycle after the first rx_valid_in with tx_data_out=0xA5, MISO second byte=0xA5.
- Burst with SPI_REG_AUTO_INC_EN: bytes 0x0E,0x11,0x22,0x33 -> reg14=0x11, STATUS write dropped (no strobe), reg0=0x33. Without the macro: reg14=0x33.
- Status read: status_in=0x5C, bytes 0x8F,0x00 -> MISO second byte 0x5C. A write 0x0F,0xFF changes nothing.
- Abort: CS high after 0x02 plus 4 data bits -> no write, state IDLE. Next transaction 0x02,0x77 -> reg2=0x77.
- Reset mid-write: assert reset_n_in low between the command and data bytes -> all regs 0 immediately, no strobe; after release a fresh transaction works.
